// File: rtl/mdu_exec_unit.sv
// -----------------------------------------------------------------------------
// mdu_exec_unit
//   Multi-cycle multiply/divide execution unit. Takes one ready entry from the
//   MDU reservation station, computes a 64-bit HI/LO result, then holds the
//   result on the CDB until the arbiter grants it. Only one op is in flight.
//
//   Optional build macro: MDU_DIV_EARLY_EXIT_EN
//     When defined, a divide whose divisor is zero or whose dividend magnitude
//     is below the divisor magnitude finishes 2 cycles after accept instead
//     of 34.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   flush             synchronous drop of any in-flight or held operation
//   issue_valid/ready issue handshake (ready only while idle)
//   issue_rob_addr    ROB address of the entry (broadcast as reference id)
//   issue_exc_type    exception type, passed through unchanged
//   issue_op          0=MULT 1=MULTU 2=DIV 3=DIVU, others=NOP
//   issue_operand_1/2 rs / rt values
//   cdb_valid/grant   result request / arbiter acceptance
//   cdb_rob_addr, cdb_exc_type, cdb_hi, cdb_lo  broadcast result
//   busy              unit is not idle
// -----------------------------------------------------------------------------
module mdu_exec_unit #(
  parameter int ROB_ADDR_W = 4,
  parameter int EXC_W      = 8,
  parameter int OP_W       = 3,
  parameter int MUL_LAT    = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  issue_valid,
  output logic                  issue_ready,
  input  logic [ROB_ADDR_W-1:0] issue_rob_addr,
  input  logic [EXC_W-1:0]      issue_exc_type,
  input  logic [OP_W-1:0]       issue_op,
  input  logic [31:0]           issue_operand_1,
  input  logic [31:0]           issue_operand_2,
  output logic                  cdb_valid,
  input  logic                  cdb_grant,
  output logic [ROB_ADDR_W-1:0] cdb_rob_addr,
  output logic [EXC_W-1:0]      cdb_exc_type,
  output logic [31:0]           cdb_hi,
  output logic [31:0]           cdb_lo,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  localparam logic [5:0] MUL_CNT_INIT = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_FIX_CNT  = 6'd33;

  state_t                state_q;
  logic [5:0]            cnt_q;
  logic [31:0]           a_q, b_q;
  logic                  signed_q;
  logic [31:0]           rem_q, quo_q, dvsr_q;
  logic [ROB_ADDR_W-1:0] cdb_rob_q;
  logic [EXC_W-1:0]      cdb_exc_q;
  logic [31:0]           cdb_hi_q, cdb_lo_q;

  // Issue decode
  logic is_mul_op, is_div_op, is_signed_op;
  assign is_mul_op    = (issue_op == OP_W'(0)) || (issue_op == OP_W'(1));
  assign is_div_op    = (issue_op == OP_W'(2)) || (issue_op == OP_W'(3));
  assign is_signed_op = (issue_op == OP_W'(0)) || (issue_op == OP_W'(2));

  // Multiplier: sign- or zero-extend to 64 bits; the low 64 bits of the
  // product are then correct for both signed and unsigned operands.
  logic [63:0] mul_a, mul_b, product;
  assign mul_a   = signed_q ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
  assign mul_b   = signed_q ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
  assign product = mul_a * mul_b;

  // Operand magnitudes for the divider
  logic [31:0] abs_a, abs_b;
  assign abs_a = (signed_q && a_q[31]) ? (~a_q + 32'd1) : a_q;
  assign abs_b = (signed_q && b_q[31]) ? (~b_q + 32'd1) : b_q;

  // One restoring-division step. The partial remainder is always below the
  // divisor, so the shifted value is below twice the divisor and the borrow
  // bit alone decides whether the subtraction is kept.
  logic [32:0] shift_d, diff_d;
  logic        take_d;
  logic [31:0] rem_d, quo_d;
  assign shift_d = {rem_q, quo_q[31]};
  assign diff_d  = shift_d - {1'b0, dvsr_q};
  assign take_d  = ~diff_d[32];
  assign rem_d   = take_d ? diff_d[31:0] : shift_d[31:0];
  assign quo_d   = {quo_q[30:0], take_d};

  // Sign fix: quotient negative when operand signs differ, remainder follows
  // the dividend. Divide-by-zero overrides with all-ones / dividend.
  logic [31:0] quo_fix, rem_fix;
  assign quo_fix = (signed_q && (a_q[31] ^ b_q[31])) ? (~quo_q + 32'd1) : quo_q;
  assign rem_fix = (signed_q && a_q[31]) ? (~rem_q + 32'd1) : rem_q;

  logic early_exit;
`ifdef MDU_DIV_EARLY_EXIT_EN
  assign early_exit = (b_q == 32'd0) || (abs_a < abs_b);
`else
  assign early_exit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      cdb_rob_q <= '0;
      cdb_exc_q <= '0;
      cdb_hi_q  <= '0;
      cdb_lo_q  <= '0;
    end else if (flush) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (issue_valid) begin
            cdb_rob_q <= issue_rob_addr;
            cdb_exc_q <= issue_exc_type;
            b_q       <= issue_operand_2;
            signed_q  <= is_signed_op;
            if (is_mul_op) begin
              state_q <= MUL;
              cnt_q   <= MUL_CNT_INIT;
              a_q     <= issue_operand_1;
            end else if (is_div_op) begin
              state_q <= DIV;
              cnt_q   <= '0;
              a_q     <= issue_operand_1;
            end else begin
              // NOP rides the multiplier for one cycle with a zero operand,
              // which yields hi=lo=0.
              state_q <= MUL;
              cnt_q   <= '0;
              a_q     <= '0;
            end
          end
        end
        MUL: begin
          if (cnt_q == '0) begin
            cdb_hi_q <= product[63:32];
            cdb_lo_q <= product[31:0];
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - 6'd1;
          end
        end
        DIV: begin
          if (cnt_q == '0) begin
            // Preparation cycle
            if (early_exit) begin
              quo_q <= '0;
              rem_q <= abs_a;
              cnt_q <= DIV_FIX_CNT;
            end else begin
              quo_q  <= abs_a;
              rem_q  <= '0;
              dvsr_q <= abs_b;
              cnt_q  <= 6'd1;
            end
          end else if (cnt_q == DIV_FIX_CNT) begin
            if (b_q == 32'd0) begin
              cdb_lo_q <= 32'hFFFF_FFFF;
              cdb_hi_q <= a_q;
            end else begin
              cdb_lo_q <= quo_fix;
              cdb_hi_q <= rem_fix;
            end
            state_q <= DONE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 6'd1;
          end
        end
        DONE: begin
          if (cdb_grant) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign issue_ready  = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign cdb_valid    = (state_q == DONE);
  assign cdb_rob_addr = cdb_rob_q;
  assign cdb_exc_type = cdb_exc_q;
  assign cdb_hi       = cdb_hi_q;
  assign cdb_lo       = cdb_lo_q;

endmodule

// File: doc/mdu_exec_unit.md
Name: mdu_exec_unit

Overview:
- Multi-cycle multiply/divide execution unit fed by the MDU reservation-station lines.
- Accepts one ready entry (ROB address, exception type, opcode, two resolved operands), computes the 64-bit HI/LO result, then holds it for the common data bus (CDB) until the arbiter grants it.
- The ROB address is broadcast as the reference id. HI drives the primary data channel; LO drives the lo channel.

Parameters:
ROB_ADDR_W, 4, ROB address width.
EXC_W, 8, exception type width; passed through unchanged.
OP_W, 3, opcode width.
MUL_LAT, 3, cycles from accept edge to result_valid for multiplies; legal range 1..8.

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
flush  in  1  sync, active-high; drops any in-flight or held operation
issue_valid  in  1  RS presents a ready entry
issue_ready  out  1  unit can accept an entry this cycle
issue_rob_addr  in  ROB_ADDR_W  ROB address of the entry
issue_exc_type  in  EXC_W  exception type of the entry
issue_op  in  OP_W  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, others=NOP
issue_operand_1  in  32  rs value (dividend / multiplicand)
issue_operand_2  in  32  rt value (divisor / multiplier)
cdb_valid  out  1  result held, requesting CDB
cdb_grant  in  1  arbiter accepts the result this cycle
cdb_rob_addr  out  ROB_ADDR_W  reference id for the broadcast
cdb_exc_type  out  EXC_W  exception type, latched at issue
cdb_hi  out  32  HI result
cdb_lo  out  32  LO result
busy  out  1  state != IDLE

Behaviour:
- States: IDLE, MUL, DIV, DONE.
- issue_ready = (state==IDLE). Transfer occurs on any edge where issue_valid && issue_ready; operands, op, ROB address and exception type latch at that edge.
- IDLE -> MUL for op 0/1. IDLE -> DIV for op 2/3. IDLE -> DONE for NOP ops, with hi=lo=0, after 1 cycle.
- MUL: down-counter loaded with MUL_LAT-1.
  - Product = op1*op2: signed 32x32 to 64 for MULT, unsigned for MULTU. hi=product[63:32], lo=product[31:0].
  - Enters DONE so that cdb_valid is first high exactly MUL_LAT cycles after the accept edge.
- DIV: radix-2 restoring divider on magnitudes.
  - 1 preparation cycle takes absolute values (signed op only), then 32 iteration cycles, then 1 sign-fix cycle.
  - cdb_valid is first high 34 cycles after the accept edge.
  - lo = quotient. hi = remainder.
  - Signed: quotient negative iff operand signs differ; remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (signed): lo=0x80000000, hi=0.
  - Divisor zero, both ops: lo=0xFFFFFFFF, hi=op1. Same 34-cycle latency.
- DONE: cdb_valid=1; all cdb_* outputs stable until the grant.
  - cdb_grant && cdb_valid -> IDLE on that edge. Issue is not accepted in the same cycle; issue_ready rises the following cycle.
  - cdb_grant while not in DONE is ignored.
- flush (rst high): next state IDLE from any state. An issue_valid in the same cycle is not accepted. Datapath registers may keep stale values; cdb_valid=0 from the next cycle.
- Reset (rst=0) at the edge, including mid-operation: state=IDLE, cdb_valid=0, busy=0, issue_ready=1, all cdb_* data outputs 0, counters 0. Reset takes priority over flush.
- Only one operation is in flight; there is no internal queue.

Optional Feature:
MDU_DIV_EARLY_EXIT_EN:
- Defined: in the DIV preparation cycle, if the divisor is 0 or |dividend| < |divisor| (unsigned compare of magnitudes), the unit goes directly to DONE. cdb_valid is high 2 cycles after the accept edge, with lo=0 and hi=op1 (divisor non-zero), or the divide-by-zero values (divisor zero).
- Undefined: all divides take 34 cycles.

Test Plan:
- Reset, then MULTU 0xFFFFFFFF*0xFFFFFFFF, rob 5, grant held high -> cdb_valid exactly 3 cycles after accept; hi=0xFFFFFFFE, lo=0x00000001, rob=5; issue_ready=1 the cycle after grant.
- MULT 0xFFFFFFFE * 3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- DIV -7 / 2, grant withheld 10 cycles -> valid at +34; lo=0xFFFFFFFD, hi=0xFFFFFFFF; outputs stable for all 10 wait cycles.
- DIVU 100 / 0 -> lo=0xFFFFFFFF, hi=100. Latency 34 without the macro, 2 with MDU_DIV_EARLY_EXIT_EN.
- DIV accepted, flush at cycle 10 with issue_valid high -> no cdb_valid; the issue is not taken; the next issue is accepted on the following cycle and its result is correct.
- rst=0 asserted at cycle 20 of a DIV -> next cycle cdb_valid=0, busy=0, all cdb_* = 0, issue_ready=1.
